// File: rtl/gba_gfx_pkg.sv
// Shared graphics types: BGR555 pixel, scanline width and line-buffer bank states.
package gba_gfx_pkg;

    typedef logic [14:0] bgr15_t;

    localparam int SCREEN_WIDTH = 240;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/linebuf_ram.sv
// Two-bank scanline RAM: one write port, one read port, registered read data.
module linebuf_ram
    import gba_gfx_pkg::*;
#(
    parameter int LINE_W = SCREEN_WIDTH,
    parameter int CW     = 15,
    parameter int XW     = 8
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [XW-1:0] wr_x,
    input  logic [CW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [XW-1:0] rd_x,
    output logic [CW-1:0] rd_data
);

    logic [CW-1:0] mem [2][LINE_W];

    // Read data only advances on rd_en so an in-flight pixel is not overwritten.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_bank][wr_x] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_bank][rd_x];
        end
    end

endmodule

// File: rtl/blend_line_buffer.sv
// Ping-pong scanline buffer between the blend stage and the display interface,
// with an output register plus one-entry skid for full-rate ready/valid output.
module blend_line_buffer
    import gba_gfx_pkg::*;
#(
    parameter int LINE_W = SCREEN_WIDTH,
    parameter int CW     = 15
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_color,
    input  logic          line_abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_color,
    output logic [7:0]    out_x,
    output logic          out_last,
    output logic [15:0]   lines_out
);

    localparam int XW = 8;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);

    bank_state_t   state      [2];
    bank_state_t   state_next [2];
    logic          wr_bank, rd_bank;
    logic [XW-1:0] wr_x, rd_x;
    logic          rd_active;
    logic          rd_pend, pend_last;
    logic [XW-1:0] pend_x;
    logic          skid_valid, skid_last;
    logic [XW-1:0] skid_x;
    logic [CW-1:0] skid_color;
    logic [CW-1:0] ram_data;
    logic          wr_fire, pop, free_bank;
    logic          rd_start, rd_issue, can_issue;
    logic [1:0]    held;
    logic          unused_color_msb;

    assign unused_color_msb = in_color[15];

    assign in_ready  = (state[wr_bank] == EMPTY) || (state[wr_bank] == FILLING);
    assign wr_fire   = in_valid && in_ready && !line_abort;
    assign pop       = out_valid && out_ready;
    assign free_bank = pop && out_last;

    // Pixels owned by the output stage after this edge; never exceed out reg + skid.
    assign held      = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pend} - {1'b0, pop};
    assign can_issue = (held < 2'd2);
    assign rd_start  = (state[rd_bank] == FULL) && !rd_active && can_issue;
    assign rd_issue  = rd_start || (rd_active && can_issue);

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_next[b] = state[b];
        end
        if (wr_fire) begin
            if (wr_x == X_LAST) begin
                state_next[wr_bank] = FULL;
            end else if (state[wr_bank] == EMPTY) begin
                state_next[wr_bank] = FILLING;
            end
        end else if (line_abort && (state[wr_bank] == FILLING)) begin
            state_next[wr_bank] = EMPTY;
        end
        if (rd_start) begin
            state_next[rd_bank] = DRAINING;
        end
        if (free_bank) begin
            state_next[rd_bank] = EMPTY;
        end
    end

    linebuf_ram #(
        .LINE_W (LINE_W),
        .CW     (CW),
        .XW     (XW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_fire),
        .wr_bank (wr_bank),
        .wr_x    (wr_x),
        .wr_data (in_color[CW-1:0]),
        .rd_en   (rd_issue),
        .rd_bank (rd_bank),
        .rd_x    (rd_x),
        .rd_data (ram_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                state[b] <= EMPTY;
            end
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_x       <= '0;
            rd_x       <= '0;
            rd_active  <= 1'b0;
            rd_pend    <= 1'b0;
            pend_x     <= '0;
            pend_last  <= 1'b0;
            skid_valid <= 1'b0;
            skid_x     <= '0;
            skid_last  <= 1'b0;
            skid_color <= '0;
            out_valid  <= 1'b0;
            out_color  <= '0;
            out_x      <= '0;
            out_last   <= 1'b0;
            lines_out  <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state[b] <= state_next[b];
            end

            if (wr_fire) begin
                if (wr_x == X_LAST) begin
                    wr_x    <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_x <= wr_x + 8'd1;
                end
            end else if (line_abort) begin
                wr_x <= '0;
            end

            rd_pend <= rd_issue;
            if (rd_issue) begin
                pend_x    <= rd_x;
                pend_last <= (rd_x == X_LAST);
                if (rd_x == X_LAST) begin
                    rd_x      <= '0;
                    rd_active <= 1'b0;
                end else begin
                    rd_x      <= rd_x + 8'd1;
                    rd_active <= 1'b1;
                end
            end

            if (free_bank) begin
                rd_bank   <= ~rd_bank;
                lines_out <= lines_out + 16'd1;
            end

            // Skid holds the older pixel, so it always refills the output first.
            if (!out_valid || out_ready) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_color <= skid_color;
                    out_x     <= skid_x;
                    out_last  <= skid_last;
                    if (rd_pend) begin
                        skid_color <= ram_data;
                        skid_x     <= pend_x;
                        skid_last  <= pend_last;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end else if (rd_pend) begin
                    out_valid <= 1'b1;
                    out_color <= ram_data;
                    out_x     <= pend_x;
                    out_last  <= pend_last;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid_color <= ram_data;
                skid_x     <= pend_x;
                skid_last  <= pend_last;
            end
        end
    end

endmodule

// File: doc/blend_line_buffer.md
Name: blend_line_buffer

Overview:
- Downstream of the special colour (blend/brighten) stage.
- Takes one final 15-bit BGR pixel per accepted transfer, in scanline order.
- Stores pixels in a two-bank line buffer, so the blend pipeline can render line N+1 while line N streams out to the display/LCD interface under ready/valid backpressure.

Parameters:
- LINE_W, 240: pixels per scanline.
- CW, 15: colour width (5:5:5 BGR).

Ports:
- clock, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: blended pixel valid.
- in_ready, output, 1: buffer can accept the pixel.
- in_color, input, 16: blended colour; bit 15 ignored, bits 14:0 stored.
- line_abort, input, 1: discard the partially written line (hblank resync).
- out_valid, output, 1: display pixel valid.
- out_ready, input, 1: display consumes the pixel.
- out_color, output, 15: pixel colour.
- out_x, output, 8: pixel column, 0..LINE_W-1.
- out_last, output, 1: high with the column LINE_W-1 pixel.
- lines_out, output, 16: count of fully drained lines, wraps at 65535->0.

Behaviour:
- Reset values (asynchronous on reset_n low): all outputs 0 except in_ready=1. Both banks EMPTY; wr_bank=0, rd_bank=0, wr_x=0, rd_x=0, lines_out=0.
- Bank state per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - Transfer occurs when in_valid & in_ready. Writes in_color[14:0] at wr_x in wr_bank, then wr_x++.
  - The first write into an EMPTY bank moves it to FILLING.
  - The write at wr_x=LINE_W-1 sets the bank FULL, sets wr_x=0 and toggles wr_bank.
  - in_ready = 1 iff state[wr_bank] is EMPTY or FILLING.
  - Both banks FULL/DRAINING -> in_ready=0 until a bank frees.
- Read side:
  - When state[rd_bank]==FULL and the output register is empty or being consumed, the bank moves to DRAINING and read address rd_x is issued.
  - RAM read latency is 1 cycle, so the first out_valid appears 2 cycles after the bank became FULL.
  - One output register plus a one-entry skid keeps throughput at 1 pixel/cycle with out_ready held high.
  - out_valid & !out_ready: out_color, out_x and out_last hold stable. No reads are issued beyond the skid capacity.
  - The transfer with out_last frees the bank: DRAINING -> EMPTY, rd_bank toggles, lines_out++.
- Simultaneous events:
  - A bank freed in cycle N is writable (in_ready) from cycle N+1, never combinationally in N.
  - Write-complete and read-start on the same bank in the same cycle are impossible: FULL is registered, so the read starts in N+1 at the earliest.
  - line_abort & in_valid in the same cycle: abort wins and the pixel is dropped (in_ready still reflects state). Abort sets wr_x=0; a FILLING bank returns to EMPTY. FULL/DRAINING banks and the read side are unaffected.
  - line_abort with wr_x=0: no effect.
- Reset mid-line: all data is discarded and the output drops to out_valid=0 immediately (asynchronous).
- Latency: last pixel write -> first out_valid of that line = 2 cycles when the read side is idle.

Decomposition:
- Shared package gba_gfx_pkg holds:
  - typedef bgr15_t (logic [14:0]).
  - constant SCREEN_WIDTH=240.
  - enum bank_state_t {EMPTY, FILLING, FULL, DRAINING}.
- Sub-module linebuf_ram: 1W/1R synchronous RAM, depth 2*LINE_W, address {bank, x}, registered read data, no reset on the array.
- Write control, read control and the skid register stay in blend_line_buffer.

Test Plan:
- Reset, then 240 pixels colour=x (ramp 0..239), out_ready=1 -> out_valid 2 cycles after last write; out_x 0..239 with out_color=out_x; out_last at 239; lines_out=1.
- Three lines written back-to-back, out_ready=0 -> in_ready drops after pixel 480 (both banks FULL). Raise out_ready -> in_ready returns 1 cycle after line 0's out_last; line 2 is then accepted and all 720 pixels come out in order.
- out_ready toggled 1010... during a drain -> no pixel lost or duplicated; out_color and out_x stable while stalled; drain takes 480 cycles for 240 pixels.
- Write 100 pixels, assert line_abort with in_valid=1 and colour 0x7FFF, then write 240 pixels of 0x001F -> the output line is all 0x001F and 0x7FFF never appears.
- Assert reset_n low mid-drain at out_x=57 -> out_valid=0 asynchronously, lines_out=0, in_ready=1; the next full line streams from out_x=0.
- in_color bit 15 = 1 with bits 14:0 = 0x1234 -> out_color=0x1234.
